// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and byte-to-word address helper
// for mem_port_arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;
   function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: combinational grant between fetch (I) and data (D) requesters.
// MEM_ARB_RR_EN selects round robin; otherwise D has fixed priority.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic       i_valid,
   input  logic       d_valid,
   input  arb_owner_t last,
   output logic       gnt_i,
   output logic       gnt_d
);
`ifdef MEM_ARB_RR_EN
   assign gnt_d = d_valid && (!i_valid || last == OWN_I);
`else
   logic unused_last;
   assign unused_last = last == OWN_D;
   assign gnt_d = d_valid;
`endif
   assign gnt_i = i_valid && !gnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory between fetch and
// load/store ports, one transaction in flight. Optional macro: MEM_ARB_RR_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MEM_AW  = 6,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [31:0]       i_req_addr,
   output logic              i_rsp_valid,
   output logic [DATA_W-1:0] i_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [31:0]       d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   localparam int CW = $clog2(MEM_LAT + 1);
   arb_state_t        state;
   arb_owner_t        owner, last;
   logic              we;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] rsp_data;
   logic              gnt_i, gnt_d;
   mem_arb_grant u_grant (
      .i_valid (i_req_valid),
      .d_valid (d_req_valid),
      .last    (last),
      .gnt_i   (gnt_i),
      .gnt_d   (gnt_d)
   );
   assign i_req_ready = !rst && state == IDLE && gnt_i;
   assign d_req_ready = !rst && state == IDLE && gnt_d;
   assign busy        = state != IDLE;
   assign i_rsp_data  = rsp_data;
   assign d_rsp_data  = rsp_data;
   // mem_addr/mem_wdata are loaded on accept so they hold through ISSUE/WAIT and after
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= OWN_I;
         last        <= OWN_I;
         we          <= 1'b0;
         cnt         <= '0;
         rsp_data    <= '0;
         mem_addr    <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
      end else begin
         mem_we      <= 1'b0;
         i_rsp_valid <= 1'b0;
         d_rsp_valid <= 1'b0;
         case (state)
            IDLE: if (i_req_ready || d_req_ready) begin
               state    <= ISSUE;
               owner    <= gnt_d ? OWN_D : OWN_I;
               last     <= gnt_d ? OWN_D : OWN_I;
               we       <= gnt_d && d_req_we;
               mem_we   <= gnt_d && d_req_we;
               mem_addr <= MEM_AW'(word_addr(gnt_d ? d_req_addr : i_req_addr));
               if (gnt_d && d_req_we) mem_wdata <= d_req_wdata;
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= CW'(MEM_LAT - 1);
            end
            WAIT: if (cnt == '0) begin
               state       <= RESP;
               rsp_data    <= (owner == OWN_D && we) ? '0 : mem_rdata;
               i_rsp_valid <= owner == OWN_I;
               d_rsp_valid <= owner == OWN_D;
            end else begin
               cnt <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with MEM_LAT=1 (dut)
// and MEM_LAT=3 (dut3), both fed from one behavioural memory.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req_valid = 1'b0, i_req_ready, i_rsp_valid;
   logic [31:0] i_req_addr = '0, i_rsp_data;
   logic        d_req_valid = 1'b0, d_req_ready, d_req_we = 1'b0, d_rsp_valid;
   logic [31:0] d_req_addr = '0, d_req_wdata = '0, d_rsp_data;
   logic [5:0]  mem_addr;
   logic        mem_we, busy;
   logic [31:0] mem_wdata, mem_rdata;
   logic        b_valid = 1'b0, b_ready, b_rsp_valid, b_d_ready, b_d_rsp_valid, b_mem_we, b_busy;
   logic [31:0] b_addr = '0, b_rsp_data, b_d_rsp_data, b_mem_wdata, b_rdata, r1, r2;
   logic [5:0]  b_mem_addr;
   logic        bd_we = 1'b0;
   logic [5:0]  bd_a = '0;
   logic [31:0] bd_d = '0;
   logic [31:0] mem [64];
   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_W(32), .MEM_AW(6), .MEM_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   mem_port_arbiter #(.DATA_W(32), .MEM_AW(6), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .i_req_valid(b_valid), .i_req_ready(b_ready), .i_req_addr(b_addr),
      .i_rsp_valid(b_rsp_valid), .i_rsp_data(b_rsp_data),
      .d_req_valid(1'b0), .d_req_ready(b_d_ready), .d_req_we(1'b0),
      .d_req_addr(32'h0), .d_req_wdata(32'h0),
      .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
      .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata),
      .busy(b_busy)
   );

   always @(posedge clk) begin
      if (bd_we) mem[bd_a] <= bd_d;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(posedge clk) begin
      r1      <= mem[b_mem_addr];
      r2      <= r1;
      b_rdata <= r2;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] exp_g [4];
`ifdef MEM_ARB_RR_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      // backdoor preload during reset: word 4 and word 0
      step();
      bd_we = 1'b1; bd_a = 6'd4; bd_d = 32'hDEADBEEF;
      step();
      bd_a = 6'd0; bd_d = 32'hA5A50000;
      step();
      bd_we = 1'b0;
      i_req_valid = 1'b1; d_req_valid = 1'b1;
      #1;
      chk("rst_i_ready", {31'b0, i_req_ready}, 0);
      chk("rst_d_ready", {31'b0, d_req_ready}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_mem_addr", {26'b0, mem_addr}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rsp_data", i_rsp_data, 0);
      chk("rst_rsp_valid", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      step();
      rst = 1'b0;
      step();

      // 1: I read 0x10
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      #1;
      chk("t1_ready", {30'b0, i_req_ready, d_req_ready}, 32'b10);
      step();
      i_req_valid = 1'b0;
      chk("t1_mem_addr", {26'b0, mem_addr}, 4);
      chk("t1_busy", {31'b0, busy}, 1);
      chk("t1_mem_we", {31'b0, mem_we}, 0);
      step();
      chk("t1_rsp_early", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
      step();
      chk("t1_rsp_valid", {30'b0, i_rsp_valid, d_rsp_valid}, 32'b10);
      chk("t1_rsp_data", i_rsp_data, 32'hDEADBEEF);
      step();
      chk("t1_rsp_pulse", {31'b0, i_rsp_valid}, 0);
      chk("t1_idle", {31'b0, busy}, 0);

      // 2: D store 0x8 then load 0x8
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h8; d_req_wdata = 32'h12345678;
      #1;
      chk("t2_st_ready", {31'b0, d_req_ready}, 1);
      step();
      d_req_valid = 1'b0;
      chk("t2_st_we", {31'b0, mem_we}, 1);
      chk("t2_st_addr", {26'b0, mem_addr}, 2);
      chk("t2_st_wdata", mem_wdata, 32'h12345678);
      step();
      chk("t2_st_we_off", {31'b0, mem_we}, 0);
      step();
      chk("t2_st_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'b01);
      chk("t2_st_data", d_rsp_data, 0);
      step();
      d_req_valid = 1'b1; d_req_we = 1'b0;
      #1;
      chk("t2_ld_ready", {31'b0, d_req_ready}, 1);
      step();
      d_req_valid = 1'b0;
      step();
      step();
      chk("t2_ld_rsp", {31'b0, d_rsp_valid}, 1);
      chk("t2_ld_data", d_rsp_data, 32'h12345678);
      step();

      // 3: both valid for four transactions, pointer reset to "I last served"
      rst = 1'b1;
      step();
      rst = 1'b0;
      i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b0;
      #1;
      for (int n = 0; n < 4; n++) begin
         int k = 0;
         while (!(i_req_ready || d_req_ready) && k < 20) begin
            step();
            k++;
         end
         chk($sformatf("t3_grant%0d", n), {30'b0, i_req_ready, d_req_ready}, {30'b0, exp_g[n]});
         step();
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      repeat (4) step();

      // 5: reset at T+2 of a D load
      d_req_valid = 1'b1; d_req_addr = 32'h10;
      #1;
      chk("t5_ready", {31'b0, d_req_ready}, 1);
      step();
      d_req_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("t5_busy", {31'b0, busy}, 0);
      chk("t5_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
      chk("t5_we", {31'b0, mem_we}, 0);
      step();
      rst = 1'b0;
      chk("t5_no_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
      step();
      chk("t5_no_rsp2", {30'b0, i_rsp_valid, d_rsp_valid}, 0);
      i_req_valid = 1'b1; i_req_addr = 32'h10;
      #1;
      chk("t5_i_ready", {31'b0, i_req_ready}, 1);
      step();
      i_req_valid = 1'b0;
      step();
      step();
      chk("t5_i_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'b10);
      chk("t5_i_data", i_rsp_data, 32'hDEADBEEF);
      step();

      // 6: address 0x103 wraps to word 0
      d_req_valid = 1'b1; d_req_addr = 32'h103;
      #1;
      chk("t6_ready", {31'b0, d_req_ready}, 1);
      step();
      d_req_valid = 1'b0;
      chk("t6_mem_addr", {26'b0, mem_addr}, 0);
      step();
      step();
      chk("t6_rsp", {31'b0, d_rsp_valid}, 1);
      chk("t6_data", d_rsp_data, 32'hA5A50000);
      step();

      // 4: MEM_LAT=3, valid held high to probe the next accept
      b_valid = 1'b1; b_addr = 32'h10;
      #1;
      chk("t4_ready_T", {31'b0, b_ready}, 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("t4_ready_T%0d", k), {31'b0, b_ready}, 0);
         chk($sformatf("t4_rsp_T%0d", k), {31'b0, b_rsp_valid}, (k == 5) ? 1 : 0);
      end
      chk("t4_data", b_rsp_data, 32'hDEADBEEF);
      step();
      chk("t4_ready_T6", {31'b0, b_ready}, 1);
      b_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
